// File: rtl/my_pkg.sv
// my_pkg: shared writeback control layout and datapath constants.
package my_pkg;
  localparam int XLEN = 32;
  localparam logic [4:0] REG_X0 = 5'd0;
  typedef logic [2:0] WB_ctrl;
  localparam int RegWrite = 2;
  localparam int MemtoReg = 1;
  localparam int PCtoReg = 0;
endpackage

// File: rtl/rf_array.sv
// rf_array: register storage, one write port and two read ports; index 0 and
// out-of-range indices read as zero and are never written.
module rf_array
  import my_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter logic [XLEN-1:0] RST_VAL = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);
  logic [XLEN-1:0] mem [DEPTH];
  always_ff @(posedge clk or posedge rst)
    if (rst)
      for (int i = 0; i < DEPTH; i++) mem[i] <= (i == 0) ? '0 : RST_VAL;
    else if (we && waddr != REG_X0 && int'(waddr) < DEPTH)
      mem[waddr] <= wdata;
  assign rdata1 = (raddr1 == REG_X0 || int'(raddr1) >= DEPTH) ? '0 : mem[raddr1];
  assign rdata2 = (raddr2 == REG_X0 || int'(raddr2) >= DEPTH) ? '0 : mem[raddr2];
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: writeback select, write-first register file reads and forward registers.
// Optional retired-write counter output wb_count when WB_RETIRE_CNT_EN is defined.
module wb_regfile
  import my_pkg::*;
#(
  parameter int RF_DEPTH = 32,
  parameter logic [XLEN-1:0] RST_VAL = 32'h0
) (
  input  logic            clk,
  input  logic            rst,
  input  WB_ctrl          in_WB,
  input  logic [XLEN-1:0] in_PC_link,
  input  logic [XLEN-1:0] in_mem_data,
  input  logic [XLEN-1:0] in_ALU_res,
  input  logic [4:0]      in_Rd,
  input  logic            in_Rd_EQ0,
  input  logic            en,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_we,
  output logic            fwd_valid,
  output logic [4:0]      fwd_Rd,
  output logic [XLEN-1:0] fwd_data
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [XLEN-1:0] wb_count
`endif
);
  logic [XLEN-1:0] rd1, rd2;
  assign wb_data = in_WB[PCtoReg] ? in_PC_link : in_WB[MemtoReg] ? in_mem_data : in_ALU_res;
  assign wb_we = en & in_WB[RegWrite] & ~in_Rd_EQ0 & (in_Rd != REG_X0);
  rf_array #(.DEPTH(RF_DEPTH), .RST_VAL(RST_VAL)) u_rf (
    .clk(clk), .rst(rst), .we(wb_we), .waddr(in_Rd), .wdata(wb_data),
    .raddr1(rs1_addr), .raddr2(rs2_addr), .rdata1(rd1), .rdata2(rd2)
  );
  // write-first bypass so decode sees the value retiring this cycle
  assign rs1_data = (rs1_addr == REG_X0) ? '0 : (wb_we && rs1_addr == in_Rd) ? wb_data : rd1;
  assign rs2_data = (rs2_addr == REG_X0) ? '0 : (wb_we && rs2_addr == in_Rd) ? wb_data : rd2;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      fwd_valid <= 1'b0;
      fwd_Rd <= '0;
      fwd_data <= '0;
    end else begin
      fwd_valid <= wb_we;
      if (wb_we) begin
        fwd_Rd <= in_Rd;
        fwd_data <= wb_data;
      end
    end
`ifdef WB_RETIRE_CNT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) wb_count <= '0;
    else if (wb_we) wb_count <= wb_count + 1'b1;
`endif
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: scoreboard bench; stimulus queues expectations, a negedge monitor checks them.
module tb_wb_regfile;
  import my_pkg::*;
  logic clk = 1'b0, rst = 1'b1, en = 1'b1, in_Rd_EQ0 = 1'b0;
  WB_ctrl in_WB = '0;
  logic [31:0] in_PC_link = '0, in_mem_data = '0, in_ALU_res = '0;
  logic [4:0] in_Rd = '0, rs1_addr = '0, rs2_addr = '0;
  logic [31:0] rs1_data, rs2_data, wb_data, fwd_data;
  logic wb_we, fwd_valid;
  logic [4:0] fwd_Rd;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0] wb_count;
`endif
  wb_regfile dut (
    .clk(clk), .rst(rst), .in_WB(in_WB), .in_PC_link(in_PC_link), .in_mem_data(in_mem_data),
    .in_ALU_res(in_ALU_res), .in_Rd(in_Rd), .in_Rd_EQ0(in_Rd_EQ0), .en(en),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_data(wb_data), .wb_we(wb_we), .fwd_valid(fwd_valid), .fwd_Rd(fwd_Rd), .fwd_data(fwd_data)
`ifdef WB_RETIRE_CNT_EN
    , .wb_count(wb_count)
`endif
  );
  always #5 clk = ~clk;
  localparam int S_RS1 = 0, S_RS2 = 1, S_WE = 2, S_FV = 3, S_FRD = 4, S_FD = 5, S_WBD = 6, S_CNT = 7;
  typedef struct {int cyc; int sig; logic [31:0] val; string name;} exp_t;
  exp_t q[$];
  int cyc = 0, errors = 0, checks = 0;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [31:0] probe(int sig);
    case (sig)
      S_RS1: return rs1_data;
      S_RS2: return rs2_data;
      S_WE: return {31'b0, wb_we};
      S_FV: return {31'b0, fwd_valid};
      S_FRD: return {27'b0, fwd_Rd};
      S_FD: return fwd_data;
`ifdef WB_RETIRE_CNT_EN
      S_CNT: return wb_count;
`endif
      default: return wb_data;
    endcase
  endfunction
  always @(negedge clk)
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic [31:0] got;
      e = q.pop_front();
      got = probe(e.sig);
      checks++;
      if (got !== e.val) begin
        errors++;
        $display("FAIL %s: got %h expected %h (cycle %0d)", e.name, got, e.val, cyc);
      end
    end
  task automatic expect_at(int dly, int sig, logic [31:0] val, string name);
    q.push_back('{cyc + dly, sig, val, name});
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(logic [2:0] wb, logic [4:0] rd, logic [31:0] pc, logic [31:0] md, logic [31:0] alu);
    in_WB = wb; in_Rd = rd; in_PC_link = pc; in_mem_data = md; in_ALU_res = alu;
  endtask
  initial begin
    repeat (2) tick();
    rst = 1'b0;
    rs1_addr = 5;
    expect_at(0, S_RS1, 0, "reset_x5");
    expect_at(0, S_FV, 0, "reset_fwd_valid");
    expect_at(0, S_FRD, 0, "reset_fwd_rd");
    expect_at(0, S_FD, 0, "reset_fwd_data");
    tick();
    drive(3'b110, 5, 32'h200, 32'hDEADBEEF, 32'h1);
    expect_at(0, S_WBD, 32'hDEADBEEF, "sel_mem");
    expect_at(0, S_WE, 1, "we_mem");
    expect_at(0, S_RS1, 32'hDEADBEEF, "bypass_x5");
    expect_at(1, S_FV, 1, "fwd_valid_x5");
    expect_at(1, S_FRD, 5, "fwd_rd_x5");
    expect_at(1, S_FD, 32'hDEADBEEF, "fwd_data_x5");
    tick();
    drive(3'b000, 5, 32'h200, 32'hDEADBEEF, 32'h1);
    expect_at(0, S_RS1, 32'hDEADBEEF, "read_x5");
    expect_at(0, S_RS2, 0, "read_x0");
    expect_at(0, S_WBD, 32'h1, "sel_alu");
    expect_at(0, S_WE, 0, "we_idle");
    expect_at(1, S_FV, 0, "fwd_valid_idle");
    tick();
    drive(3'b100, 7, 32'h0, 32'h0, 32'h77);
    tick();
    drive(3'b000, 0, 32'h0, 32'h0, 32'h0);
    rs1_addr = 7;
    expect_at(0, S_RS1, 32'h77, "read_x7");
    tick();
    drive(3'b100, 0, 32'h0, 32'h0, 32'h55);
    rs1_addr = 0;
    expect_at(0, S_WE, 0, "guard_rd0");
    expect_at(0, S_RS1, 0, "guard_x0_read");
    expect_at(1, S_FV, 0, "guard_rd0_fv");
    tick();
    drive(3'b100, 7, 32'h0, 32'h0, 32'h66);
    in_Rd_EQ0 = 1'b1;
    expect_at(0, S_WE, 0, "guard_eq0");
    expect_at(1, S_FV, 0, "guard_eq0_fv");
    expect_at(1, S_FD, 32'h77, "guard_fd_held");
    tick();
    drive(3'b000, 0, 32'h0, 32'h0, 32'h0);
    in_Rd_EQ0 = 1'b0;
    rs1_addr = 0; rs2_addr = 7;
    expect_at(0, S_RS1, 0, "x0_unchanged");
    expect_at(0, S_RS2, 32'h77, "x7_unchanged");
    tick();
    drive(3'b111, 9, 32'h104, 32'hDEADBEEF, 32'h9);
    rs1_addr = 9; rs2_addr = 9;
    expect_at(0, S_RS1, 32'h104, "bypass_rs1_x9");
    expect_at(0, S_RS2, 32'h104, "bypass_rs2_x9");
    expect_at(0, S_WBD, 32'h104, "sel_pc_priority");
    tick();
    drive(3'b100, 3, 32'h0, 32'h0, 32'h33);
    en = 1'b0;
    rs1_addr = 3;
    expect_at(0, S_WE, 0, "stall_we");
    expect_at(0, S_RS1, 0, "stall_no_bypass");
    expect_at(0, S_RS2, 32'h104, "read_x9");
    expect_at(1, S_FV, 0, "stall_fv");
    expect_at(1, S_FD, 32'h104, "stall_fd_held");
    expect_at(1, S_FRD, 9, "stall_frd_held");
    tick();
    drive(3'b000, 0, 32'h0, 32'h0, 32'h0);
    en = 1'b1;
    expect_at(0, S_RS1, 0, "stall_x3_unchanged");
    tick();
    rst = 1'b1;
    rs1_addr = 5; rs2_addr = 9;
    expect_at(0, S_RS1, 0, "async_rst_x5");
    expect_at(0, S_RS2, 0, "async_rst_x9");
    expect_at(0, S_FV, 0, "async_rst_fv");
    expect_at(0, S_FD, 0, "async_rst_fd");
    tick();
    drive(3'b100, 6, 32'h0, 32'h0, 32'h66);
    rs1_addr = 7;
    expect_at(0, S_RS1, 0, "async_rst_x7");
    tick();
    rst = 1'b0;
    drive(3'b000, 0, 32'h0, 32'h0, 32'h0);
    rs1_addr = 6;
    expect_at(0, S_RS1, 0, "rst_write_discarded");
    expect_at(0, S_FV, 0, "rst_fv_after");
    tick();
    drive(3'b100, 6, 32'h0, 32'h0, 32'h61);
    tick();
    drive(3'b000, 0, 32'h0, 32'h0, 32'h0);
    expect_at(0, S_RS1, 32'h61, "first_write_after_rst");
    expect_at(0, S_FRD, 6, "first_write_frd");
`ifdef WB_RETIRE_CNT_EN
    tick();
    force dut.wb_count = 32'hFFFFFFFF;
    #1 release dut.wb_count;
    drive(3'b100, 4, 32'h0, 32'h0, 32'h44);
    expect_at(0, S_CNT, 32'hFFFFFFFF, "cnt_preload");
    expect_at(1, S_CNT, 32'h0, "cnt_wrap");
    tick();
    drive(3'b000, 0, 32'h0, 32'h0, 32'h0);
`endif
    for (int i = 0; i < 20 && q.size() > 0; i++) tick();
    if (q.size() > 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have parameter RF_DEPTH, default 32, giving the number of architectural registers (index 0 hard-wired to zero).
REQ-002 SHALL have parameter RST_VAL, default 32'h0, giving the reset value of registers 1..RF_DEPTH-1.
REQ-003 SHALL have port clk  input  1  -- the single clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  -- asynchronous, active-high reset.
REQ-005 SHALL have port in_WB  input  WB_ctrl (3)  -- {RegWrite, MemtoReg, PCtoReg} from the MEM/WB register.
REQ-006 SHALL have ports in_PC_link, in_mem_data and in_ALU_res, each input 32, carrying the writeback candidates.
REQ-007 SHALL have port in_Rd  input  5  -- destination register index.
REQ-008 SHALL have port in_Rd_EQ0  input  1  -- flag that the destination is x0.
REQ-009 SHALL have port en  input  1  -- writeback enable (low means stall).
REQ-010 SHALL have ports rs1_addr and rs2_addr, each input 5, as the decode-stage read addresses.
REQ-011 SHALL have ports rs1_data and rs2_data, each output 32, as the read data.
REQ-012 SHALL have port wb_data  output 32  -- the selected writeback value (combinational).
REQ-013 SHALL have port wb_we  output 1  -- the qualified write strobe (combinational).
REQ-014 SHALL have ports fwd_valid (output 1), fwd_Rd (output 5) and fwd_data (output 32) as the registered copy of the last qualified write, used by the EX forwarding unit.

Function
REQ-015 SHALL select wb_data with priority PCtoReg -> in_PC_link, else MemtoReg -> in_mem_data, else in_ALU_res.
REQ-016 SHALL assert wb_we = en & RegWrite & ~in_Rd_EQ0 & (in_Rd != 0); the write is suppressed if either x0 indication is present.
REQ-017 SHALL write wb_data into register in_Rd at the posedge on which wb_we=1; a write to an index >= RF_DEPTH SHALL be ignored.
REQ-018 SHALL return 0 on rsN_data whenever rsN_addr = 0, regardless of any write.
REQ-019 SHALL read write-first: when wb_we=1 and rsN_addr = in_Rd != 0, rsN_data SHALL equal wb_data in the same cycle; otherwise it SHALL be the stored value.
REQ-020 SHALL capture fwd_valid <= wb_we, and fwd_Rd <= in_Rd and fwd_data <= wb_data when wb_we=1, so that all three lag by exactly 1 cycle.
REQ-021 SHALL, when en=0, leave the register file unchanged, hold fwd_Rd and fwd_data, and clear fwd_valid.
REQ-022 SHALL, when both read ports address the same register, return identical data on both.

Reset
REQ-023 SHALL, while rst=1, immediately force registers 1..RF_DEPTH-1 to RST_VAL, and fwd_valid, fwd_Rd and fwd_data to 0.
REQ-024 SHALL discard a write coincident with rst assertion; the first write SHALL occur on the first posedge after rst deasserts.

Configuration
REQ-025 SHALL, with macro WB_RETIRE_CNT_EN defined, add output wb_count (32 bits) that is reset to 0, increments on every posedge with wb_we=1, and wraps from 32'hFFFFFFFF to 0.
REQ-026 SHALL, without WB_RETIRE_CNT_EN, have neither the wb_count port nor its counter logic.

Structure
REQ-027 SHALL take WB_ctrl and the field positions RegWrite, MemtoReg and PCtoReg from the shared package my_pkg.
REQ-028 SHALL place the constants REG_X0 = 5'd0 and XLEN = 32 in my_pkg.
REQ-029 SHALL implement the storage array as sub-module rf_array (1 write port, 2 read ports); selection, bypass and forward registers SHALL live in wb_regfile.

Verification
REQ-030 SHALL cover a reset check: assert rst mid-run -> all registers read 0 and fwd_valid=0 without waiting for a clock edge.
REQ-031 SHALL cover writeback selection: in_WB=RegWrite|MemtoReg, in_Rd=5, in_mem_data=32'hDEADBEEF, in_ALU_res=32'h1 -> x5 reads 32'hDEADBEEF next cycle, fwd_Rd=5, fwd_valid=1.
REQ-032 SHALL cover the x0 guard: RegWrite with in_Rd=0, or with in_Rd=7 and in_Rd_EQ0=1 -> wb_we=0, x0 and x7 unchanged, fwd_valid=0.
REQ-033 SHALL cover the bypass: rs1_addr=rs2_addr=9 while writing x9 with in_PC_link=32'h104 (PCtoReg) -> both read ports show 32'h104 in the same cycle.
REQ-034 SHALL cover the stall: en=0 with RegWrite, in_Rd=3 -> x3 unchanged, fwd_valid drops to 0, fwd_data held.
REQ-035 SHALL cover counter wrap (with WB_RETIRE_CNT_EN): preload wb_count to 32'hFFFFFFFF via forced state, perform one qualified write -> wb_count=0.
